// File: rtl/pc_return_stack_if.sv
// Bus between the instruction control stage and the PC / return stack.
// The control stage is the master: it drives the enable and strobes and
// observes the fetch address and stack status.
interface pc_return_stack_if #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              en;
    logic              jump;
    logic              ret;
    logic              push;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  depth;
    logic [ADDR_W-1:0] tos;
    logic              ovf;
    logic              unf;

    modport master (
        output en, jump, ret, push, target,
        input  pc, depth, tos, ovf, unf
    );

    modport slave (
        input  en, jump, ret, push, target,
        output pc, depth, tos, ovf, unf
    );
endinterface

// File: rtl/pc_return_stack.sv
// Program counter with an integrated hardware call/return stack.
// One action per enabled cycle; ret outranks call, call outranks plain
// jump, plain jump outranks push-only, otherwise the PC just increments.
// Overflow and underflow flags are sticky until reset.
module pc_return_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    pc_return_stack_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];

    logic [ADDR_W-1:0] pcInc;
    logic [PTR_W-1:0]  wrIdx;
    logic [PTR_W-1:0]  topIdx;
    logic              stackEmpty;
    logic              stackFull;
    logic              stackWrEn;

    // The return address is pc+1 wrapped to the address width; the write
    // slot is the current depth and the top entry sits one below it.
    // When the stack is full the low depth bits are zero, so topIdx still
    // wraps around to DEPTH-1 correctly.
    assign pcInc      = pc_q + ADDR_W'(1);
    assign wrIdx      = depth_q[PTR_W-1:0];
    assign topIdx     = depth_q[PTR_W-1:0] - PTR_W'(1);
    assign stackEmpty = (depth_q == '0);
    assign stackFull  = (depth_q == CNT_W'(DEPTH));

    // Select the single action for this cycle and form the next state.
    always_comb begin
        pc_d      = pc_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        stackWrEn = 1'b0;
        if (bus.en) begin
            if (bus.ret) begin
                if (stackEmpty) begin
                    pc_d  = pcInc;
                    unf_d = 1'b1;
                end else begin
                    pc_d    = stack_q[topIdx];
                    depth_d = depth_q - CNT_W'(1);
                end
            end else if (bus.push) begin
                pc_d = bus.jump ? bus.target : pcInc;
                if (stackFull) begin
                    ovf_d = 1'b1;
                end else begin
                    stackWrEn = 1'b1;
                    depth_d   = depth_q + CNT_W'(1);
                end
            end else if (bus.jump) begin
                pc_d = bus.target;
            end else begin
                pc_d = pcInc;
            end
        end
    end

    // Control registers with synchronous reset overriding enable and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset; a push coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && stackWrEn) begin
            stack_q[wrIdx] <= pcInc;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.depth = depth_q;
    assign bus.tos   = stackEmpty ? '0 : stack_q[topIdx];
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench for pc_return_stack: the stimulus process queues the
// hand-computed state expected after each edge, a monitor pops and compares.
module tb_pc_return_stack;
    logic clk;
    logic rst;

    pc_return_stack_if #(.ADDR_W(8), .DEPTH(8)) bus ();

    pc_return_stack #(.ADDR_W(8), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [21:0] exp;
    } sbItem_t;

    sbItem_t sbQ[$];
    int      checks = 0;
    int      errors = 0;

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got pc=%h depth=%0d tos=%h ovf=%b unf=%b, expected pc=%h depth=%0d tos=%h ovf=%b unf=%b",
                     nm, act[21:14], act[13:10], act[9:2], act[1], act[0],
                     exp[21:14], exp[13:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: after each edge, compare the DUT state against the queued entry.
    always @(posedge clk) begin
        sbItem_t item;
        #2;
        if (sbQ.size() > 0) begin
            item = sbQ.pop_front();
            checkOutput(item.name, {bus.pc, bus.depth, bus.tos, bus.ovf, bus.unf}, item.exp);
        end
    end

    task automatic applyStimulus(input logic r, input logic e, input logic j, input logic rt,
                                 input logic p, input logic [7:0] tgt,
                                 input logic [7:0] ePc, input logic [3:0] eDepth,
                                 input logic [7:0] eTos, input logic eOvf, input logic eUnf,
                                 input string nm);
        sbItem_t item;
        @(negedge clk);
        rst        = r;
        bus.en     = e;
        bus.jump   = j;
        bus.ret    = rt;
        bus.push   = p;
        bus.target = tgt;
        item.name  = nm;
        item.exp   = {ePc, eDepth, eTos, eOvf, eUnf};
        sbQ.push_back(item);
    endtask

    initial begin
        logic [7:0] ePc;
        logic [7:0] eTos;
        logic [7:0] tgt;
        int         d;
        int         waitCycles;

        rst = 1'b1; bus.en = 1'b0; bus.jump = 1'b0; bus.ret = 1'b0;
        bus.push = 1'b0; bus.target = '0;

        // Reset and increment
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, "reset0");
        applyStimulus(1, 1, 1, 0, 1, 8'h77, 8'h00, 0, 8'h00, 0, 0, "reset1");
        for (int i = 1; i <= 5; i++) begin
            ePc = 8'(i);
            applyStimulus(0, 1, 0, 0, 0, 8'h00, ePc, 0, 8'h00, 0, 0, "incr");
        end

        // Call and return
        applyStimulus(0, 1, 1, 0, 0, 8'h10, 8'h10, 0, 8'h00, 0, 0, "jump10");
        applyStimulus(0, 1, 1, 0, 1, 8'h40, 8'h40, 1, 8'h11, 0, 0, "call40");
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h41, 1, 8'h11, 0, 0, "idle41");
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h42, 1, 8'h11, 0, 0, "idle42");
        applyStimulus(0, 1, 0, 1, 0, 8'h00, 8'h11, 0, 8'h00, 0, 0, "ret11");

        // Nesting and overflow from pc=0
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, "resetNest");
        for (int k = 1; k <= 9; k++) begin
            tgt = 8'h80 + 8'(k - 1);
            if (k <= 8) begin
                eTos = (k == 1) ? 8'h01 : tgt;
                applyStimulus(0, 1, 1, 0, 1, tgt, tgt, 4'(k), eTos, 0, 0, "nestCall");
            end else begin
                applyStimulus(0, 1, 1, 0, 1, tgt, 8'h88, 8, 8'h87, 1, 0, "ovfCall");
            end
        end
        for (int j = 1; j <= 8; j++) begin
            d    = 8 - j;
            ePc  = (d == 0) ? 8'h01 : 8'h80 + 8'(d);
            eTos = (d == 0) ? 8'h00 : ((d == 1) ? 8'h01 : 8'h80 + 8'(d - 1));
            applyStimulus(0, 1, 0, 1, 0, 8'h00, ePc, 4'(d), eTos, 1, 0, "nestRet");
        end

        // Underflow, sticky until reset
        applyStimulus(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, "resetUnf");
        applyStimulus(0, 1, 1, 0, 0, 8'h20, 8'h20, 0, 8'h00, 0, 0, "jump20");
        applyStimulus(0, 1, 0, 1, 0, 8'h00, 8'h21, 0, 8'h00, 0, 1, "unfRet");
        for (int i = 0; i < 10; i++) begin
            ePc = 8'h22 + 8'(i);
            applyStimulus(0, 1, 0, 0, 0, 8'h00, ePc, 0, 8'h00, 0, 1, "unfSticky");
        end
        applyStimulus(1, 1, 0, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, "unfClear");

        // Stall and priority
        applyStimulus(0, 1, 1, 0, 0, 8'h32, 8'h32, 0, 8'h00, 0, 0, "jump32");
        applyStimulus(0, 1, 1, 0, 1, 8'h60, 8'h60, 1, 8'h33, 0, 0, "call60");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 8'h55, 8'h60, 1, 8'h33, 0, 0, "stall");
        end
        applyStimulus(0, 1, 1, 1, 1, 8'h55, 8'h33, 0, 8'h00, 0, 0, "retPriority");

        // Wrap, call at top of address space, reset during a call
        applyStimulus(0, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, "jumpFF");
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, "wrapIncr");
        applyStimulus(0, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 8'h00, 0, 0, "jumpFF2");
        applyStimulus(0, 1, 1, 0, 1, 8'h10, 8'h10, 1, 8'h00, 0, 0, "wrapCall");
        applyStimulus(1, 1, 1, 0, 1, 8'h90, 8'h00, 0, 8'h00, 0, 0, "resetDuringCall");
        applyStimulus(0, 1, 0, 0, 0, 8'h00, 8'h01, 0, 8'h00, 0, 0, "afterReset");
        applyStimulus(0, 1, 0, 0, 1, 8'h00, 8'h02, 1, 8'h02, 0, 0, "pushOnly");
        applyStimulus(0, 1, 0, 1, 0, 8'h00, 8'h02, 0, 8'h00, 0, 0, "retPushOnly");

        @(negedge clk);
        bus.en = 1'b0; bus.jump = 1'b0; bus.ret = 1'b0; bus.push = 1'b0;

        // Drain the scoreboard within a bounded number of cycles.
        waitCycles = 0;
        while (sbQ.size() > 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_return_stack.md
Name: pc_return_stack

Overview:
- Program counter with an integrated hardware call/return stack for the small 4-bit-opcode processor.
- Sits directly downstream of the instruction control stage and consumes its registered jump, return and push strobes.
- Produces the fetch address each cycle and tracks subroutine nesting.
- Includes sticky overflow and underflow flags for debug and trap logic.

Parameters:
ADDR_W, 8, program address width in bits; PC wraps modulo 2^ADDR_W
DEPTH, 8, number of return-stack entries; must be a power of two and at least 2

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  advance enable; 0 = stall, all state held
jump  input  1  load PC from target (from control stage jump strobe)
ret  input  1  pop return address into PC (from control stage return strobe)
push  input  1  push PC+1 onto stack (from control stage push strobe; call when with jump)
target  input  ADDR_W  jump/call destination address from instruction operand
pc  output  ADDR_W  current fetch address
depth  output  $clog2(DEPTH)+1  number of valid stack entries, 0..DEPTH
tos  output  ADDR_W  top-of-stack value; 0 when depth=0
ovf  output  1  sticky: push attempted while full
unf  output  1  sticky: ret attempted while empty

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1:
  - pc=0, depth=0, ovf=0, unf=0, tos=0.
  - Stack contents are don't-care.
  - rst overrides en and all strobes.
  - rst asserted mid-call or mid-return discards the pending update.
- Stall: en=0 -> pc, depth, stack contents, ovf and unf all hold; strobes are ignored.
- When en=1, exactly one action per cycle, in this priority order:
  1. ret=1:
     - If depth>0: pc <= stack[depth-1], depth <= depth-1.
     - If depth=0: pc <= pc+1, unf <= 1, depth stays 0.
     - jump and push are ignored in the same cycle; ret dominates.
  2. jump=1 and push=1 (call):
     - If depth<DEPTH: stack[depth] <= pc+1, depth <= depth+1.
     - If full: stack and depth are unchanged and ovf <= 1.
     - In both cases pc <= target.
  3. jump=1 only: pc <= target; stack unchanged.
  4. push=1 only: if not full, stack[depth] <= pc+1 and depth <= depth+1, else ovf <= 1. pc <= pc+1.
  5. No strobe: pc <= pc+1.
- Arithmetic: pc+1 is computed in ADDR_W bits and wraps, so 2^ADDR_W-1 -> 0. The pushed return address wraps the same way.
- Latency: a strobe sampled at edge N takes effect in pc and depth after edge N. No combinational path from inputs to outputs.
- tos is combinational from the registered stack and depth: stack[depth-1] when depth>0, else 0.
- ovf and unf are sticky until rst.
- Call-then-return in consecutive cycles is legal. The returned value is the one pushed the previous cycle; no bypass is needed because the push is registered.
- Stack storage is a register array. Read and write within the same cycle are impossible because ret has priority.

Test Plan:
- Reset and increment: rst=1 for 2 cycles, then en=1 with no strobes for 5 cycles -> pc=0 during reset, then pc = 1, 2, 3, 4, 5; depth=0; ovf=unf=0.
- Call/return: at pc=0x10, jump=1, push=1, target=0x40 -> pc=0x40, depth=1, tos=0x11. Two idle cycles -> pc=0x42. Then ret=1 -> pc=0x11, depth=0, tos=0.
- Nesting and overflow (DEPTH=8): 9 consecutive calls with target=0x80+i starting at pc=0x00:
  - Calls 1-8 push 0x01, 0x81, 0x82, ... and depth reaches 8.
  - Call 9: pc=0x88, depth stays 8, ovf=1, tos=0x87.
  - 8 rets -> pc sequence 0x87, 0x86, ..., 0x81, 0x01; depth=0.
- Underflow: depth=0, pc=0x20, ret=1 -> pc=0x21, unf=1, depth=0. unf stays 1 through 10 more cycles until rst.
- Stall and priority:
  - en=0 with jump=1, target=0x55 for 3 cycles -> pc unchanged.
  - Then en=1 with ret=1, jump=1, push=1 at depth=1, tos=0x33 -> pc=0x33, depth=0, no push.
- Wrap and reset mid-operation:
  - pc=0xFF with no strobe -> pc=0x00.
  - Call at pc=0xFF -> tos=0x00.
  - rst=1 asserted in the same cycle as a call -> pc=0, depth=0, no push recorded.
